// File: rtl/ndp_xbar_oq.sv
// ndp_xbar_oq -- NUM_IN x NUM_OUT output-queued crossbar for the NDP switch core.
//
// Sits between the ingress queue stage and the egress MACs. Each egress owns a
// FIFO of depth 2**QDEPTH_LOG2. Beats that target the same egress in the same
// cycle are arbitrated round-robin. The winner is enqueued. Losers, and a
// winner that meets a full queue, are dropped and counted per egress.
//
// Handshake: in_valid is a one-cycle beat strobe. Ingress cannot be stalled, so
// a beat that is not enqueued in its cycle is lost. On egress, out_rdy[j]=1 in
// cycle t lets a queued head beat be popped at the end of t. That beat is then
// presented with out_wr[j]=1 in cycle t+1. out_ctl/out_data hold their value
// whenever out_wr is low.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    [NUM_IN]              per-ingress beat valid
//   in_ctl      [NUM_IN*CTRL_WIDTH]   ctl words; the dest field is at DEST_LSB
//   in_data     [NUM_IN*DATA_WIDTH]   data words
//   out_rdy     [NUM_OUT]             egress may accept a beat
//   out_wr      [NUM_OUT]             registered egress beat strobe
//   out_ctl     [NUM_OUT*CTRL_WIDTH]  registered egress ctl
//   out_data    [NUM_OUT*DATA_WIDTH]  registered egress data
//   q_depth     [NUM_OUT*(QDEPTH_LOG2+1)]  per-egress occupancy
//   drop_cnt    [NUM_OUT*16]          per-egress saturating drop counter
//   bad_dest    pulse, a valid beat addressed a non-existent egress last cycle
//
// Optional feature, macro NDP_WATERMARK_EN:
//   wm_clr      reload each high-water mark with the current depth
//   q_hwm       [NUM_OUT*(QDEPTH_LOG2+1)]  per-egress depth high-water mark
module ndp_xbar_oq #(
   parameter int DATA_WIDTH  = 480,
   parameter int CTRL_WIDTH  = 32,
   parameter int NUM_IN      = 4,
   parameter int NUM_OUT     = 6,
   parameter int QDEPTH_LOG2 = 4,
   parameter int DEST_LSB    = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_IN-1:0]                     in_valid,
   input  logic [NUM_IN*CTRL_WIDTH-1:0]          in_ctl,
   input  logic [NUM_IN*DATA_WIDTH-1:0]          in_data,
   input  logic [NUM_OUT-1:0]                    out_rdy,
   output logic [NUM_OUT-1:0]                    out_wr,
   output logic [NUM_OUT*CTRL_WIDTH-1:0]         out_ctl,
   output logic [NUM_OUT*DATA_WIDTH-1:0]         out_data,
   output logic [NUM_OUT*(QDEPTH_LOG2+1)-1:0]    q_depth,
   output logic [NUM_OUT*16-1:0]                 drop_cnt,
`ifdef NDP_WATERMARK_EN
   input  logic                                  wm_clr,
   output logic [NUM_OUT*(QDEPTH_LOG2+1)-1:0]    q_hwm,
`endif
   output logic                                  bad_dest
);

   localparam int DEST_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int CNT_W  = QDEPTH_LOG2 + 1;
   localparam int DEPTH  = 1 << QDEPTH_LOG2;
   localparam int ENT_W  = CTRL_WIDTH + DATA_WIDTH;

   localparam logic [DEST_W:0]      NUM_OUT_V = (DEST_W+1)'(NUM_OUT);
   localparam logic [PTR_W-1:0]     LAST_IN   = PTR_W'(NUM_IN - 1);
   localparam logic [CNT_W-1:0]     FULL_V    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0]     RR_ONE    = PTR_W'(1);
   localparam logic [QDEPTH_LOG2-1:0] QP_ONE  = QDEPTH_LOG2'(1);

   // ingress decode
   logic [DEST_W-1:0]      dest     [NUM_IN];
   logic [NUM_IN-1:0]      bad_vec;

   // per-egress arbitration
   logic [NUM_IN-1:0]      req      [NUM_OUT];
   logic [NUM_OUT-1:0]     win_vld;
   logic [PTR_W-1:0]       win_idx  [NUM_OUT];
   logic [4:0]             drops    [NUM_OUT];
   logic [NUM_OUT-1:0]     full;
   logic [NUM_OUT-1:0]     enq;
   logic [NUM_OUT-1:0]     deq;
   logic [ENT_W-1:0]       wdata    [NUM_OUT];

   // state
   logic [PTR_W-1:0]       rr_q     [NUM_OUT];
   logic [PTR_W-1:0]       rr_d     [NUM_OUT];
   logic [QDEPTH_LOG2-1:0] wr_ptr_q [NUM_OUT];
   logic [QDEPTH_LOG2-1:0] rd_ptr_q [NUM_OUT];
   logic [CNT_W-1:0]       cnt_q    [NUM_OUT];
   logic [CNT_W-1:0]       cnt_d    [NUM_OUT];
   logic [15:0]            drop_q   [NUM_OUT];
   logic [15:0]            drop_d   [NUM_OUT];
   logic [NUM_OUT-1:0]     out_wr_q;
   logic [CTRL_WIDTH-1:0]  out_ctl_q  [NUM_OUT];
   logic [DATA_WIDTH-1:0]  out_data_q [NUM_OUT];
   logic                   bad_q;
   logic [ENT_W-1:0]       mem_q    [NUM_OUT][DEPTH];

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         dest[i]    = in_ctl[i*CTRL_WIDTH + DEST_LSB +: DEST_W];
         bad_vec[i] = in_valid[i] && ({1'b0, dest[i]} >= NUM_OUT_V);
      end
   end

   always_comb begin
      int idx;
      logic [16:0] sum;
      idx = 0;
      sum = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         win_vld[j] = 1'b0;
         win_idx[j] = '0;
         drops[j]   = '0;
         rr_d[j]    = rr_q[j];
         cnt_d[j]   = cnt_q[j];
         for (int i = 0; i < NUM_IN; i++) begin
            req[j][i] = in_valid[i] && !bad_vec[i] && (dest[i] == DEST_W'(j));
         end
         // Scan starts at the RR pointer and wraps; the first hit wins.
         for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_q[j]) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!win_vld[j] && req[j][idx]) begin
               win_vld[j] = 1'b1;
               win_idx[j] = PTR_W'(idx);
            end
            drops[j] = drops[j] + 5'(req[j][k]);
         end
         // Full is judged on the registered depth; a same-cycle pop frees nothing.
         full[j] = (cnt_q[j] == FULL_V);
         enq[j]  = win_vld[j] && !full[j];
         deq[j]  = (cnt_q[j] != '0) && out_rdy[j];
         // Every requester is a drop except a winner that actually got in.
         if (enq[j]) drops[j] = drops[j] - 5'd1;
         if (win_vld[j]) begin
            rr_d[j] = (win_idx[j] == LAST_IN) ? '0 : win_idx[j] + RR_ONE;
         end
         wdata[j] = {in_ctl[win_idx[j]*CTRL_WIDTH +: CTRL_WIDTH],
                     in_data[win_idx[j]*DATA_WIDTH +: DATA_WIDTH]};
         case ({enq[j], deq[j]})
            2'b10:   cnt_d[j] = cnt_q[j] + CNT_ONE;
            2'b01:   cnt_d[j] = cnt_q[j] - CNT_ONE;
            default: cnt_d[j] = cnt_q[j];
         endcase
         sum       = {1'b0, drop_q[j]} + 17'(drops[j]);
         drop_d[j] = sum[16] ? 16'hFFFF : sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            rr_q[j]       <= '0;
            wr_ptr_q[j]   <= '0;
            rd_ptr_q[j]   <= '0;
            cnt_q[j]      <= '0;
            drop_q[j]     <= '0;
            out_ctl_q[j]  <= '0;
            out_data_q[j] <= '0;
         end
         out_wr_q <= '0;
         bad_q    <= 1'b0;
      end else begin
         for (int j = 0; j < NUM_OUT; j++) begin
            rr_q[j]     <= rr_d[j];
            cnt_q[j]    <= cnt_d[j];
            drop_q[j]   <= drop_d[j];
            out_wr_q[j] <= deq[j];
            if (enq[j]) wr_ptr_q[j] <= wr_ptr_q[j] + QP_ONE;
            if (deq[j]) begin
               out_ctl_q[j]  <= mem_q[j][rd_ptr_q[j]][ENT_W-1 -: CTRL_WIDTH];
               out_data_q[j] <= mem_q[j][rd_ptr_q[j]][DATA_WIDTH-1:0];
               rd_ptr_q[j]   <= rd_ptr_q[j] + QP_ONE;
            end
         end
         bad_q <= |bad_vec;
      end
   end

   // Queue storage needs no reset: pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      for (int j = 0; j < NUM_OUT; j++) begin
         if (enq[j]) mem_q[j][wr_ptr_q[j]] <= wdata[j];
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         out_ctl[j*CTRL_WIDTH +: CTRL_WIDTH]  = out_ctl_q[j];
         out_data[j*DATA_WIDTH +: DATA_WIDTH] = out_data_q[j];
         q_depth[j*CNT_W +: CNT_W]            = cnt_q[j];
         drop_cnt[j*16 +: 16]                 = drop_q[j];
      end
   end

   assign out_wr   = out_wr_q;
   assign bad_dest = bad_q;

`ifdef NDP_WATERMARK_EN
   logic [CNT_W-1:0] hwm_q [NUM_OUT];

   // Tracks the largest depth reached; wm_clr restarts it from the current depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NUM_OUT; j++) hwm_q[j] <= '0;
      end else begin
         for (int j = 0; j < NUM_OUT; j++) begin
            if (wm_clr)                  hwm_q[j] <= cnt_q[j];
            else if (cnt_d[j] > hwm_q[j]) hwm_q[j] <= cnt_d[j];
         end
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) q_hwm[j*CNT_W +: CNT_W] = hwm_q[j];
   end
`endif

endmodule

// File: tb/tb_ndp_xbar_oq.sv
// Testbench for ndp_xbar_oq at default parameters (4 in, 6 out, depth 16).
// A queue-based reference model of the switch is stepped once per cycle from
// the inputs seen at the clock edge, and every output is compared against it
// each cycle. Directed scenarios add literal expectations on top.
module tb_ndp_xbar_oq;

   localparam int NI    = 4;
   localparam int NO    = 6;
   localparam int CW    = 32;
   localparam int DW    = 480;
   localparam int DEPTH = 16;
   localparam int CNTW  = 5;

   logic                 clk;
   logic                 rst;
   logic [NI-1:0]        in_valid;
   logic [NI*CW-1:0]     in_ctl;
   logic [NI*DW-1:0]     in_data;
   logic [NO-1:0]        out_rdy;
   logic [NO-1:0]        out_wr;
   logic [NO*CW-1:0]     out_ctl;
   logic [NO*DW-1:0]     out_data;
   logic [NO*CNTW-1:0]   q_depth;
   logic [NO*16-1:0]     drop_cnt;
   logic                 bad_dest;
`ifdef NDP_WATERMARK_EN
   logic                 wm_clr;
   logic [NO*CNTW-1:0]   q_hwm;
`endif

   ndp_xbar_oq dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ctl   (in_ctl),
      .in_data  (in_data),
      .out_rdy  (out_rdy),
      .out_wr   (out_wr),
      .out_ctl  (out_ctl),
      .out_data (out_data),
      .q_depth  (q_depth),
      .drop_cnt (drop_cnt),
`ifdef NDP_WATERMARK_EN
      .wm_clr   (wm_clr),
      .q_hwm    (q_hwm),
`endif
      .bad_dest (bad_dest)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input logic [31:0] c);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = c ^ (32'h0101_0101 * 32'(k)) ^ 32'h5A5A_0F0F;
      return r;
   endfunction

   // ---------------- reference model ----------------
   logic [31:0]   exp_q [NO][$];
   int            m_rr   [NO];
   int            m_drop [NO];
   int            m_hwm  [NO];
   logic [NO-1:0] m_wr;
   logic [31:0]   m_ctl  [NO];
   logic [DW-1:0] m_data [NO];
   logic          m_bad;

   // inputs as the DUT saw them at the last rising edge
   logic [NI-1:0]    s_valid;
   logic [NI*CW-1:0] s_ctl;
   logic [NO-1:0]    s_rdy;
   logic             s_rst;
   logic             s_wm;

   always @(posedge clk) begin
      s_valid <= in_valid;
      s_ctl   <= in_ctl;
      s_rdy   <= out_rdy;
      s_rst   <= rst;
`ifdef NDP_WATERMARK_EN
      s_wm    <= wm_clr;
`else
      s_wm    <= 1'b0;
`endif
   end

   task automatic model_step();
      int old_d [NO];
      int nreq, win, loss, i, d;
      if (s_rst) begin
         for (int j = 0; j < NO; j++) begin
            exp_q[j].delete();
            m_rr[j] = 0; m_drop[j] = 0; m_hwm[j] = 0;
            m_ctl[j] = '0; m_data[j] = '0;
         end
         m_wr  = '0;
         m_bad = 1'b0;
      end else begin
         for (int j = 0; j < NO; j++) begin
            old_d[j] = exp_q[j].size();
            if (old_d[j] > 0 && s_rdy[j]) begin
               m_wr[j]   = 1'b1;
               m_ctl[j]  = exp_q[j].pop_front();
               m_data[j] = mk_data(m_ctl[j]);
            end else begin
               m_wr[j] = 1'b0;
            end
         end
         m_bad = 1'b0;
         for (int k = 0; k < NI; k++) begin
            d = int'(s_ctl[k*CW +: 3]);
            if (s_valid[k] && d >= NO) m_bad = 1'b1;
         end
         for (int j = 0; j < NO; j++) begin
            nreq = 0; win = -1;
            for (int k = 0; k < NI; k++) begin
               i = (m_rr[j] + k) % NI;
               d = int'(s_ctl[i*CW +: 3]);
               if (s_valid[i] && d == j) begin
                  nreq++;
                  if (win < 0) win = i;
               end
            end
            if (win >= 0) begin
               loss = nreq - 1;
               if (old_d[j] == DEPTH) loss++;
               else exp_q[j].push_back(s_ctl[win*CW +: CW]);
               m_rr[j]   = (win + 1) % NI;
               m_drop[j] = m_drop[j] + loss;
               if (m_drop[j] > 65535) m_drop[j] = 65535;
            end
            if (s_wm) m_hwm[j] = old_d[j];
            else if (exp_q[j].size() > m_hwm[j]) m_hwm[j] = exp_q[j].size();
         end
      end
   endtask

   task automatic compare();
      for (int j = 0; j < NO; j++) begin
         check($sformatf("out_wr[%0d]", j),   512'(out_wr[j]), 512'(m_wr[j]));
         check($sformatf("out_ctl[%0d]", j),  512'(out_ctl[j*CW +: CW]), 512'(m_ctl[j]));
         check($sformatf("out_data[%0d]", j), 512'(out_data[j*DW +: DW]), 512'(m_data[j]));
         check($sformatf("q_depth[%0d]", j),  512'(q_depth[j*CNTW +: CNTW]), 512'(exp_q[j].size()));
         check($sformatf("drop_cnt[%0d]", j), 512'(drop_cnt[j*16 +: 16]), 512'(m_drop[j]));
`ifdef NDP_WATERMARK_EN
         check($sformatf("q_hwm[%0d]", j),    512'(q_hwm[j*CNTW +: CNTW]), 512'(m_hwm[j]));
`endif
      end
      check("bad_dest", 512'(bad_dest), 512'(m_bad));
   endtask

   // scoreboard process: model and compare every cycle, away from the active edge
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         model_step();
         compare();
      end
   end

   // ---------------- driver tasks ----------------
   int          seq;
   logic [31:0] last_ctl [NI];

   task automatic drive_beat(input int i, input int dst);
      logic [31:0] sv;
      logic [31:0] c;
      sv  = 32'(seq);
      c   = {sv[23:0], 5'd0, 3'(dst)};
      seq++;
      in_valid[i]           = 1'b1;
      in_ctl[i*CW +: CW]    = c;
      in_data[i*DW +: DW]   = mk_data(c);
      last_ctl[i]           = c;
   endtask

   task automatic clear_in();
      in_valid = '0;
   endtask

   function automatic logic [31:0] ctl_of(input int j);
      return out_ctl[j*CW +: CW];
   endfunction

   function automatic logic [15:0] drop_of(input int j);
      return drop_cnt[j*16 +: 16];
   endfunction

   function automatic logic [CNTW-1:0] depth_of(input int j);
      return q_depth[j*CNTW +: CNTW];
   endfunction

   // ---------------- directed stimulus ----------------
   logic [31:0]      c0, c1;
   logic [31:0]      saved [32];
   logic [NO*16-1:0] exp_drop;
   int               pulses;

   initial begin
      rst = 1'b1; in_valid = '0; in_ctl = '0; in_data = '0; out_rdy = '1; seq = 1;
`ifdef NDP_WATERMARK_EN
      wm_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset out_wr",   512'(out_wr), 512'(0));
      check("reset q_depth",  512'(q_depth), 512'(0));
      check("reset drop_cnt", 512'(drop_cnt), 512'(0));
      check("reset out_ctl",  512'(out_ctl), 512'(0));
      check("reset bad_dest", 512'(bad_dest), 512'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post-reset out_wr", 512'(out_wr), 512'(0));

      // single beat in0 -> egress 2, two-cycle latency
      drive_beat(0, 2); c0 = last_ctl[0];
      @(negedge clk); clear_in();
      check("single depth t+1", 512'(depth_of(2)), 512'(1));
      check("single out_wr t+1", 512'(out_wr), 512'(0));
      @(negedge clk);
      check("single out_wr t+2", 512'(out_wr), 512'(6'b000100));
      check("single ctl", 512'(ctl_of(2)), 512'(c0));
      check("single data", 512'(out_data[2*DW +: DW]), 512'(mk_data(c0)));
      check("single depth t+2", 512'(depth_of(2)), 512'(0));
      check("single no drops", 512'(drop_cnt), 512'(0));

      // four-way contention on egress 1, round-robin from 0 then 1
      for (int i = 0; i < NI; i++) drive_beat(i, 1);
      c0 = last_ctl[0];
      @(negedge clk);
      check("rr drop 3", 512'(drop_of(1)), 512'(3));
      for (int i = 0; i < NI; i++) drive_beat(i, 1);
      c1 = last_ctl[1];
      @(negedge clk); clear_in();
      check("rr drop 6", 512'(drop_of(1)), 512'(6));
      check("rr first wr", 512'(out_wr[1]), 512'(1));
      check("rr first winner in0", 512'(ctl_of(1)), 512'(c0));
      @(negedge clk);
      check("rr second wr", 512'(out_wr[1]), 512'(1));
      check("rr second winner in1", 512'(ctl_of(1)), 512'(c1));
      @(negedge clk);

      // fill egress 4 while it is stalled
      out_rdy[4] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         drive_beat(2, 4); saved[n] = last_ctl[2];
         @(negedge clk);
      end
      check("fill depth 16", 512'(depth_of(4)), 512'(16));
      check("fill drop 4", 512'(drop_of(4)), 512'(4));
      // release with a same-cycle enqueue onto the full queue
      out_rdy[4] = 1'b1;
      drive_beat(2, 4);
      @(negedge clk); clear_in();
      check("full+pop depth 15", 512'(depth_of(4)), 512'(15));
      check("full+pop drop 5", 512'(drop_of(4)), 512'(5));
      check("drain first wr", 512'(out_wr[4]), 512'(1));
      check("drain first ctl", 512'(ctl_of(4)), 512'(saved[0]));
      pulses = 1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_wr[4]) begin
            if (pulses < 20) check($sformatf("drain order %0d", pulses), 512'(ctl_of(4)), 512'(saved[pulses]));
            pulses++;
         end
      end
      check("drain beat count", 512'(pulses), 512'(16));

      // out-of-range destination
      drive_beat(3, 7);
      @(negedge clk); clear_in();
      exp_drop = '0;
      exp_drop[1*16 +: 16] = 16'd6;
      exp_drop[4*16 +: 16] = 16'd5;
      check("bad_dest pulse", 512'(bad_dest), 512'(1));
      check("bad_dest no out_wr", 512'(out_wr), 512'(0));
      check("bad_dest drops unchanged", 512'(drop_cnt), 512'(exp_drop));
      @(negedge clk);
      check("bad_dest clears", 512'(bad_dest), 512'(0));
      check("bad_dest still no out_wr", 512'(out_wr), 512'(0));

      // reset with ten beats queued on egress 0
      out_rdy[0] = 1'b0;
      for (int n = 0; n < 10; n++) begin
         drive_beat(1, 0);
         @(negedge clk);
      end
      clear_in();
      check("queued depth 10", 512'(depth_of(0)), 512'(10));
`ifdef NDP_WATERMARK_EN
      check("hwm 10 before reset", 512'(q_hwm[0 +: CNTW]), 512'(10));
`endif
      out_rdy = '1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid reset out_wr", 512'(out_wr), 512'(0));
      check("mid reset q_depth", 512'(q_depth), 512'(0));
      check("mid reset drop_cnt", 512'(drop_cnt), 512'(0));
      check("mid reset out_ctl", 512'(out_ctl), 512'(0));
`ifdef NDP_WATERMARK_EN
      check("mid reset hwm", 512'(q_hwm), 512'(0));
`endif
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check($sformatf("no stale beat %0d", n), 512'(out_wr), 512'(0));
      end

`ifdef NDP_WATERMARK_EN
      // watermark reload: depth 3 -> drain to 1 -> wm_clr loads 1
      out_rdy[0] = 1'b0;
      for (int n = 0; n < 3; n++) begin
         drive_beat(1, 0);
         @(negedge clk);
      end
      clear_in();
      check("wm hwm 3", 512'(q_hwm[0 +: CNTW]), 512'(3));
      out_rdy[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("wm depth 1", 512'(depth_of(0)), 512'(1));
      check("wm hwm holds 3", 512'(q_hwm[0 +: CNTW]), 512'(3));
      out_rdy[0] = 1'b0;
      wm_clr = 1'b1;
      @(negedge clk);
      wm_clr = 1'b0;
      check("wm_clr loads depth", 512'(q_hwm[0 +: CNTW]), 512'(1));
      out_rdy = '1;
      repeat (3) @(negedge clk);
`endif

      // drop counter saturation on stalled egress 5: 48 + 4*(16387-16) = 65532
      out_rdy[5] = 1'b0;
      repeat (16387) begin
         for (int i = 0; i < NI; i++) drive_beat(i, 5);
         @(negedge clk);
      end
      clear_in();
      drive_beat(0, 5);
      drive_beat(1, 5);
      @(negedge clk);
      check("sat drop FFFE", 512'(drop_of(5)), 512'(16'hFFFE));
      for (int i = 0; i < NI; i++) drive_beat(i, 5);
      @(negedge clk);
      check("sat drop FFFF", 512'(drop_of(5)), 512'(16'hFFFF));
      @(negedge clk);
      check("sat drop holds", 512'(drop_of(5)), 512'(16'hFFFF));
      clear_in();
      out_rdy = '1;
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ndp_xbar_oq.md
Name: ndp_xbar_oq

Overview:
- Parametrised NUM_IN x NUM_OUT crossbar; each egress has its own output queue and backlog measurement.
- Generalises the fixed 4-in crossbar to an N:M NDP switch core (default 4:6), with per-egress FIFOs, round-robin arbitration, egress backpressure and drop accounting.
- Sits between the ingress queue stage and the 100G egress MACs.
- Backlog (queue depth) per egress is exported every cycle for the congestion-measurement logic.

Parameters:
- DATA_WIDTH, 480, data word width per beat.
- CTRL_WIDTH, 32, control word width per beat.
- NUM_IN, 4, ingress channel count (1..16).
- NUM_OUT, 6, egress channel count (1..16).
- QDEPTH_LOG2, 4, log2 of per-egress FIFO depth (depth 16).
- DEST_LSB, 0, LSB of the destination-port field in the ctl word; field width is clog2(NUM_OUT), minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_IN  per-ingress beat valid; no backpressure toward ingress.
- in_ctl  in  NUM_IN*CTRL_WIDTH  ingress ctl words, channel i at [i*CTRL_WIDTH +: CTRL_WIDTH].
- in_data  in  NUM_IN*DATA_WIDTH  ingress data words, packed the same way.
- out_rdy  in  NUM_OUT  egress may accept a beat this cycle.
- out_wr  out  NUM_OUT  registered egress beat strobe.
- out_ctl  out  NUM_OUT*CTRL_WIDTH  registered egress ctl.
- out_data  out  NUM_OUT*DATA_WIDTH  registered egress data.
- q_depth  out  NUM_OUT*(QDEPTH_LOG2+1)  per-egress occupancy, 0..2^QDEPTH_LOG2.
- drop_cnt  out  NUM_OUT*16  per-egress saturating drop counter.
- bad_dest  out  1  one-cycle pulse when any valid beat carries dest >= NUM_OUT.

Behaviour:
- Reset values: out_wr=0, out_ctl=0, out_data=0, q_depth=0, drop_cnt=0, bad_dest=0. All FIFOs are emptied and all RR pointers go to 0.
- Reset mid-operation discards all queued beats. No out_wr in the cycle after rst is deasserted.
- Routing: dest of input i = in_ctl[i][DEST_LSB +: DW].
- A valid beat with dest >= NUM_OUT is discarded and raises bad_dest next cycle. It is not counted in any drop_cnt.
- Arbitration (per egress j, combinational each cycle):
  - Requesters are the inputs with in_valid=1 and dest==j.
  - Round-robin winner is the first requester at index >= rr_ptr[j], wrapping.
  - When a winner exists, rr_ptr[j] <= (winner+1) mod NUM_IN.
  - Losers are dropped; drop_cnt[j] += number of losers.
- Enqueue: the winner is written at the clock edge unless q_depth[j]==2^QDEPTH_LOG2. If full, the winner is also dropped (+1 drop).
- Full is judged on the current depth. There is no same-cycle bypass: a dequeue in the same cycle does not free space.
- drop_cnt arithmetic: adds up to NUM_IN per cycle and saturates at 16'hFFFF, never wrapping.
- Dequeue: when FIFO j is non-empty and out_rdy[j]=1, the head entry goes to out_ctl/out_data and out_wr[j]=1 next cycle. Otherwise out_wr[j]=0 and out_ctl/out_data hold their last value.
- Latency: a beat presented at cycle t to an empty queue with out_rdy=1 appears with out_wr at cycle t+2. Minimum and typical are equal.
- q_depth[j] is registered: +1 on enqueue, -1 on dequeue, unchanged when both happen. It never exceeds 2^QDEPTH_LOG2 or goes below 0.
- Ordering: FIFO order per egress. Beats from the same ingress to the same egress are never reordered.
- FIFO storage is read/write pointers with wrap-around mod 2^QDEPTH_LOG2, plus the count register.

Optional Feature:
- Macro: NDP_WATERMARK_EN.
- Defined:
  - Adds input wm_clr (1) and output q_hwm (NUM_OUT*(QDEPTH_LOG2+1)).
  - q_hwm[j] <= max(q_hwm[j], next q_depth[j]) each cycle.
  - wm_clr=1 loads q_hwm[j] with the current q_depth[j].
  - Reset value is 0.
- Undefined: those ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Single beat, in0 dest=2, out_rdy=all 1 at cycle 5 -> out_wr[2]=1 at cycle 7 with matching ctl/data; q_depth[2] goes 0->1->0; no drops.
- in0..in3 all dest=1 for 1 cycle, rr_ptr[1]=0 -> in0 enqueued, drop_cnt[1]=3. Repeat -> in1 wins, drop_cnt[1]=6.
- out_rdy[4]=0, in2 dest=4 for 20 consecutive cycles -> q_depth[4] saturates at 16, drop_cnt[4]=4. Raise out_rdy[4] -> exactly 16 beats emitted in order.
- Full queue with out_rdy=1 and a same-cycle enqueue -> beat dropped (+1), depth 16->15.
- in3 ctl dest=7 (NUM_OUT=6) -> bad_dest pulse next cycle, no out_wr, drop_cnt unchanged. Also force drop_cnt to 0xFFFE, then 4 losers -> 0xFFFF.
- Assert rst with 10 beats queued on egress 0 -> all outputs 0 next cycle; no stale beats afterwards. With NDP_WATERMARK_EN: q_hwm[0]=10 before reset, 0 after; wm_clr reloads it with the current depth.
